// File: rtl/des_round_key_sequencer.sv
// des_round_key_sequencer: iterative DES key schedule, one 48-bit subkey per
// handshake; define DES_KEY_PARITY_CHECK_EN for the odd-parity key check.
module des_round_key_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:64] key,
   input  logic        decrypt,
   input  logic        start,
   input  logic        abort,
   output logic [1:48] subkey,
   output logic [4:0]  round,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic        busy,
   output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
   ,
   output logic        parity_err
`endif
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t      r_state;
   logic [1:28] r_c;
   logic [1:28] r_d;
   logic [4:0]  r_round;
   logic        r_dir;
   logic        r_done;

   logic [1:28] w_pc1_c;
   logic [1:28] w_pc1_d;
   logic [1:28] w_load_c;
   logic [1:28] w_load_d;
   logic [1:28] w_c_next;
   logic [1:28] w_d_next;
   logic [4:0]  w_next_idx;
   logic        w_two;
   logic        w_accept;

   assign w_pc1_c = {
      key[57], key[49], key[41], key[33],
      key[25], key[17], key[9],  key[1],
      key[58], key[50], key[42], key[34],
      key[26], key[18], key[10], key[2],
      key[59], key[51], key[43], key[35],
      key[27], key[19], key[11], key[3],
      key[60], key[52], key[44], key[36]
   };

   assign w_pc1_d = {
      key[63], key[55], key[47], key[39],
      key[31], key[23], key[15], key[7],
      key[62], key[54], key[46], key[38],
      key[30], key[22], key[14], key[6],
      key[61], key[53], key[45], key[37],
      key[29], key[21], key[13], key[5],
      key[28], key[20], key[12], key[4]
   };

   // Encrypt starts from C1/D1, decrypt from C16/D16 which equals C0/D0.
   assign w_load_c = decrypt ? w_pc1_c
                             : {w_pc1_c[2:28], w_pc1_c[1]};
   assign w_load_d = decrypt ? w_pc1_d
                             : {w_pc1_d[2:28], w_pc1_d[1]};

   // PC-2 straight off the C/D registers; D bits are renumbered 1..28.
   assign subkey = {
      r_c[14], r_c[17], r_c[11], r_c[24],
      r_c[1],  r_c[5],  r_c[3],  r_c[28],
      r_c[15], r_c[6],  r_c[21], r_c[10],
      r_c[23], r_c[19], r_c[12], r_c[4],
      r_c[26], r_c[8],  r_c[16], r_c[7],
      r_c[27], r_c[20], r_c[13], r_c[2],
      r_d[13], r_d[24], r_d[3],  r_d[9],
      r_d[19], r_d[27], r_d[2],  r_d[12],
      r_d[23], r_d[17], r_d[5],  r_d[20],
      r_d[16], r_d[21], r_d[11], r_d[28],
      r_d[6],  r_d[25], r_d[18], r_d[14],
      r_d[22], r_d[8],  r_d[1],  r_d[4]
   };

   // Key index whose shift amount governs the step being taken.
   assign w_next_idx = r_dir ? (5'd17 - r_round)
                             : (r_round + 5'd1);

   // Shift schedule: one position for keys 1, 2, 9 and 16, else two.
   always_comb begin
      unique case (w_next_idx)
         5'd1, 5'd2, 5'd9, 5'd16: w_two = 1'b0;
         default:                 w_two = 1'b1;
      endcase
   end

   // Rotate each 28-bit half: left when encrypting, right when decrypting.
   always_comb begin
      if (r_dir) begin
         w_c_next = w_two ? {r_c[27:28], r_c[1:26]}
                          : {r_c[28], r_c[1:27]};
         w_d_next = w_two ? {r_d[27:28], r_d[1:26]}
                          : {r_d[28], r_d[1:27]};
      end else begin
         w_c_next = w_two ? {r_c[3:28], r_c[1:2]}
                          : {r_c[2:28], r_c[1]};
         w_d_next = w_two ? {r_d[3:28], r_d[1:2]}
                          : {r_d[2:28], r_d[1]};
      end
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   logic r_perr;
   logic w_par_ok;

   assign w_par_ok = (^key[1:8])   & (^key[9:16])
                   & (^key[17:24]) & (^key[25:32])
                   & (^key[33:40]) & (^key[41:48])
                   & (^key[49:56]) & (^key[57:64]);
   assign w_accept   = start & w_par_ok;
   assign parity_err = r_perr;

   // Sticky parity flag, refreshed on every start seen in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perr <= 1'b0;
      end else if (!abort && r_state == S_IDLE && start) begin
         r_perr <= ~w_par_ok;
      end
   end
`else
   logic w_unused_par;

   assign w_unused_par = ^{key[8],  key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};
   assign w_accept     = start;
`endif

   // Schedule controller: load on start, step on handshake, abort wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_round <= 5'd0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
            r_round <= 5'd0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_c     <= w_load_c;
                     r_d     <= w_load_d;
                     r_dir   <= decrypt;
                     r_round <= 5'd1;
                     r_state <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (subkey_ready) begin
                     if (r_round == 5'd16) begin
                        r_state <= S_IDLE;
                        r_round <= 5'd0;
                        r_done  <= 1'b1;
                     end else begin
                        r_c     <= w_c_next;
                        r_d     <= w_d_next;
                        r_round <= r_round + 5'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign round        = r_round;
   assign subkey_valid = (r_state == S_RUN);
   assign busy         = (r_state == S_RUN);
   assign done         = r_done;

endmodule

// File: tb/tb_des_round_key_sequencer.sv
// tb_des_round_key_sequencer: scoreboard bench for the DES key sequencer,
// expected keys from an independent cumulative-rotation key schedule.
`timescale 1ns/1ps
module tb_des_round_key_sequencer;

   typedef struct packed {
      logic [4:0]  rnd;
      logic [47:0] key;
   } exp_t;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
   localparam logic [63:0] KEY_P = 64'h133457799BBCDFF0;
   localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
   localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] key = '0;
   logic        decrypt = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        subkey_ready = 1'b0;
   logic [47:0] subkey;
   logic [4:0]  round;
   logic        subkey_valid;
   logic        busy;
   logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
   logic        parity_err;
`endif

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int pc1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
   int pc2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   des_round_key_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .key          (key),
      .decrypt      (decrypt),
      .start        (start),
      .abort        (abort),
      .subkey       (subkey),
      .round        (round),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .busy         (busy),
      .done         (done)
`ifdef DES_KEY_PARITY_CHECK_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   always #5 clk = ~clk;

   // K_idx = PC2(C0, D0 each rotated left by the cumulative shift count).
   function automatic logic [47:0] ref_key(input logic [63:0] k,
                                           input int idx);
      logic [55:0] cd;
      logic [27:0] c;
      logic [27:0] d;
      logic [47:0] o;
      int          n;
      cd = '0;
      for (logic [5:0] i = 6'd0; i < 6'd56; i++)
         cd = {cd[54:0], k[6'(64 - pc1[i])]};
      n = 0;
      for (int s = 1; s <= idx; s++)
         n += (s == 1 || s == 2 || s == 9 || s == 16) ? 1 : 2;
      c = cd[55:28];
      d = cd[27:0];
      c = (c << n) | (c >> (28 - n));
      d = (d << n) | (d >> (28 - n));
      cd = {c, d};
      o = '0;
      for (logic [5:0] j = 6'd0; j < 6'd48; j++)
         o = {o[46:0], cd[6'(56 - pc2[j])]};
      return o;
   endfunction

   task automatic push_sched(input logic [63:0] k, input logic dec);
      exp_t e;
      for (int i = 1; i <= 16; i++) begin
         e.rnd = 5'(i);
         e.key = ref_key(k, dec ? 17 - i : i);
         q.push_back(e);
      end
   endtask

   task automatic kick(input logic [63:0] k, input logic dec);
      @(negedge clk);
      key = k;
      decrypt = dec;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({subkey_valid, busy, done, round, subkey} !== 56'd0) begin
         n_bad++;
         $display("FAIL reset_hold: got v%b b%b d%b r%0d k%h want all 0",
                  subkey_valid, busy, done, round, subkey);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({subkey_valid, busy, done, round, subkey} !== 56'd0) begin
         n_bad++;
         $display("FAIL reset_release: got v%b b%b d%b r%0d k%h want all 0",
                  subkey_valid, busy, done, round, subkey);
      end
`ifdef DES_KEY_PARITY_CHECK_EN
      n_cmp++;
      if (parity_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_perr: got %b want 0", parity_err);
      end
`endif
   endtask

   task automatic test_order(input logic dec);
      int          n;
      logic [47:0] first;
      logic [47:0] last;
      push_sched(KEY_A, dec);
      kick(KEY_A, dec);
      n = 0;
      first = '0;
      last = '0;
      while (q.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
         subkey_ready = 1'b1;
         n_cmp++;
         if (subkey_valid !== 1'b1 || done !== 1'b0 ||
             round !== q[0].rnd || subkey !== q[0].key) begin
            n_bad++;
            $display("FAIL order%0d_key: got v%b d%b r%0d %h want r%0d %h",
                     dec, subkey_valid, done, round, subkey,
                     q[0].rnd, q[0].key);
         end
         if (n == 1) first = subkey;
         last = subkey;
         void'(q.pop_front());
      end
      n_cmp++;
      if (n !== 16 || q.size() != 0) begin
         n_bad++;
         $display("FAIL order%0d_cycles: got %0d want 16", dec, n);
      end
      q.delete();
      n_cmp++;
      if (first !== (dec ? K16_A : K1_A) || last !== (dec ? K1_A : K16_A)) begin
         n_bad++;
         $display("FAIL order%0d_ends: got %h..%h want %h..%h", dec,
                  first, last, dec ? K16_A : K1_A, dec ? K1_A : K16_A);
      end
      @(negedge clk);
      subkey_ready = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0 ||
          round !== 5'd0) begin
         n_bad++;
         $display("FAIL order%0d_done: got d%b b%b v%b r%0d want 1 0 0 0",
                  dec, done, busy, subkey_valid, round);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL order%0d_pulse: got %b want 0", dec, done);
      end
   endtask

   task automatic test_backpressure;
      int n;
      int hs;
      push_sched(KEY_A, 1'b0);
      kick(KEY_A, 1'b0);
      n = 0;
      hs = 0;
      while (q.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
         subkey_ready = 1'($urandom_range(0, 1));
         n_cmp++;
         if (subkey_valid !== 1'b1 || done !== 1'b0 ||
             round !== q[0].rnd || subkey !== q[0].key) begin
            n_bad++;
            $display("FAIL bp_key: got v%b d%b r%0d %h want r%0d %h",
                     subkey_valid, done, round, subkey, q[0].rnd, q[0].key);
         end
         if (subkey_ready) begin
            hs++;
            void'(q.pop_front());
         end
      end
      n_cmp++;
      if (q.size() != 0 || hs != 16) begin
         n_bad++;
         $display("FAIL bp_timeout: got %0d handshakes want 16", hs);
      end
      q.delete();
      @(negedge clk);
      subkey_ready = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_done: got d%b b%b want 1 0", done, busy);
      end
   endtask

   task automatic test_abort;
      int   n;
      logic seen;
      kick(KEY_A, 1'b0);
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         n++;
         subkey_ready = 1'b1;
         if (round == 5'd5) break;
      end
      n_cmp++;
      if (round !== 5'd5 || subkey !== ref_key(KEY_A, 5)) begin
         n_bad++;
         $display("FAIL abort_reach: got r%0d %h want r5 %h",
                  round, subkey, ref_key(KEY_A, 5));
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          round !== 5'd0) begin
         n_bad++;
         $display("FAIL abort_idle: got v%b b%b d%b r%0d want 0 0 0 0",
                  subkey_valid, busy, done, round);
      end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= done;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_nodone: got %b want 0", seen);
      end
      kick(KEY_A, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (subkey_valid !== 1'b1 || round !== 5'd1 || subkey !== K1_A) begin
         n_bad++;
         $display("FAIL abort_restart: got v%b r%0d %h want 1 1 %h",
                  subkey_valid, round, subkey, K1_A);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      subkey_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      int   n;
      logic seen;
      kick(KEY_A, 1'b0);
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         n++;
         subkey_ready = 1'b1;
         if (round == 5'd9) break;
      end
      n_cmp++;
      if (round !== 5'd9) begin
         n_bad++;
         $display("FAIL rstmid_reach: got r%0d want 9", round);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({subkey_valid, busy, done, round, subkey} !== 56'd0) begin
         n_bad++;
         $display("FAIL rstmid_clear: got v%b b%b d%b r%0d %h want all 0",
                  subkey_valid, busy, done, round, subkey);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= done | busy;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_nodone: got %b want 0", seen);
      end
      kick(KEY_A, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (subkey_valid !== 1'b1 || round !== 5'd1 || subkey !== K1_A) begin
         n_bad++;
         $display("FAIL rstmid_restart: got v%b r%0d %h want 1 1 %h",
                  subkey_valid, round, subkey, K1_A);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      subkey_ready = 1'b0;
   endtask

   task automatic test_start_busy;
      int n;
      push_sched(KEY_A, 1'b0);
      kick(KEY_A, 1'b0);
      n = 0;
      while (q.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
         subkey_ready = 1'b1;
         start = (n == 3);
         key = (n == 3) ? KEY_B : KEY_A;
         decrypt = (n == 3);
         n_cmp++;
         if (subkey_valid !== 1'b1 || round !== q[0].rnd ||
             subkey !== q[0].key) begin
            n_bad++;
            $display("FAIL busy_key: got v%b r%0d %h want r%0d %h",
                     subkey_valid, round, subkey, q[0].rnd, q[0].key);
         end
         void'(q.pop_front());
      end
      start = 1'b0;
      n_cmp++;
      if (q.size() != 0 || n !== 16) begin
         n_bad++;
         $display("FAIL busy_cycles: got %0d want 16", n);
      end
      q.delete();
      @(negedge clk);
      subkey_ready = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_done: got d%b b%b want 1 0", done, busy);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      push_sched(KEY_A, 1'b0);
      kick(KEY_A, 1'b0);
      for (int s = 0; s < 2; s++) begin
         n = 0;
         while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
            subkey_ready = 1'b1;
            n_cmp++;
            if (subkey_valid !== 1'b1 || round !== q[0].rnd ||
                subkey !== q[0].key) begin
               n_bad++;
               $display("FAIL b2b%0d_key: got v%b r%0d %h want r%0d %h", s,
                        subkey_valid, round, subkey, q[0].rnd, q[0].key);
            end
            void'(q.pop_front());
         end
         n_cmp++;
         if (q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b%0d_timeout: got %0d left want 0", s, q.size());
         end
         q.delete();
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b%0d_done: got d%b b%b want 1 0", s, done, busy);
         end
         if (s == 0) begin
            key = KEY_B;
            decrypt = 1'b1;
            start = 1'b1;
            push_sched(KEY_B, 1'b1);
            @(posedge clk);
            #1;
            start = 1'b0;
         end
      end
      subkey_ready = 1'b0;
   endtask

`ifdef DES_KEY_PARITY_CHECK_EN
   task automatic test_parity;
      kick(KEY_P, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (parity_err !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL par_reject: got p%b b%b v%b want 1 0 0",
                  parity_err, busy, subkey_valid);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (parity_err !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL par_sticky: got p%b b%b want 1 0", parity_err, busy);
      end
      kick(KEY_A, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (parity_err !== 1'b0 || busy !== 1'b1 || round !== 5'd1 ||
          subkey !== K1_A) begin
         n_bad++;
         $display("FAIL par_accept: got p%b b%b r%0d %h want 0 1 1 %h",
                  parity_err, busy, round, subkey, K1_A);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_order(1'b0);
      test_order(1'b1);
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_start_busy();
      test_back_to_back();
`ifdef DES_KEY_PARITY_CHECK_EN
      test_parity();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
